aesl_deadlock_param_monitor: RTL
================================

AESL_DEADLOCK_PARAM_MONITOR -- requirements
Module: aesl_deadlock_param_monitor

Interface
REQ-001 Parameter NUM_SUB, default 2: number of monitored sub-instances; each owns one AXIS pair; legal range 1..16.
REQ-002 Parameter THRESH, default 1: consecutive blocked cycles required before block is reported; legal range 1..65535.
REQ-003 Parameter STICKY, default 0: 0 = block self-clears; 1 = block holds until clear.
REQ-004 Parameter CNT_W, default 8: width of the event counter.
REQ-005 Derived constant IDX_W = max(1, ceil(log2(NUM_SUB))).
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 clear  in  1  synchronous clear of the monitor state (not of event_cnt).
REQ-009 axis_block_sigs  in  2*NUM_SUB  bits [2i+1:2i] are the AXIS pair of sub-instance i; 1 = stalled.
REQ-010 sub_block  in  NUM_SUB  bit i = block flag from sub-monitor i.
REQ-011 axis_block_info  out  2*NUM_SUB  per-pair stall snapshot; zero while block=0.
REQ-012 block  out  1  deadlock reported.
REQ-013 first_idx  out  IDX_W  lowest index i whose pair caused entry into BLOCKED.
REQ-014 event_cnt  out  CNT_W  count of IDLE/SUSPECT->BLOCKED entries; saturating.

Function
REQ-015 cand[i] = sub_block[i] & (axis_block_sigs[2i] | axis_block_sigs[2i+1]), combinational.
REQ-016 seq_block = OR of cand[]; the block has no other combinational path to any output.
REQ-017 The FSM has three states: IDLE, SUSPECT, BLOCKED; all outputs are registered or gated by registered state.
REQ-018 IDLE: seq_block=1 and THRESH=1 -> BLOCKED; seq_block=1 and THRESH>1 -> SUSPECT with run=1; otherwise remain in IDLE with run=0.
REQ-019 SUSPECT: seq_block=0 -> IDLE with run=0; seq_block=1 and run=THRESH-1 -> BLOCKED; otherwise run increments.
REQ-020 block rises on the edge that samples the THRESH-th consecutive seq_block=1 cycle; with THRESH=1 the latency is exactly one cycle.
REQ-021 BLOCKED with STICKY=0: seq_block=0 -> IDLE on the next edge, so block falls one cycle after seq_block falls.
REQ-022 BLOCKED with STICKY=1: remain BLOCKED regardless of seq_block until clear=1.
REQ-023 On entry into BLOCKED: info[2i+1:2i] <= axis_block_sigs[2i+1:2i] & {2{cand[i]}}; first_idx <= lowest i with cand[i]=1; event_cnt increments unless it is all-ones.
REQ-024 While BLOCKED with STICKY=0 and seq_block=1: info refreshes every cycle per REQ-023 masking; first_idx and event_cnt hold.
REQ-025 While BLOCKED with STICKY=1: info and first_idx are frozen.
REQ-026 axis_block_info = info when the state is BLOCKED, otherwise all zeros.
REQ-027 clear=1 in any state -> IDLE, run=0, info=0, first_idx=0 on the next edge; clear takes priority over a simultaneous seq_block, which is evaluated fresh on the next cycle.
REQ-028 The run counter is 16 bits and never exceeds THRESH-1.

Reset
REQ-029 reset=1 asynchronously forces IDLE, run=0, info=0, first_idx=0, event_cnt=0; block=0 and axis_block_info=0 immediately.
REQ-030 Reset asserted mid-SUSPECT or in BLOCKED discards all progress; after release, detection restarts from IDLE with a full THRESH run.

Verification
REQ-031 NUM_SUB=2, THRESH=1: sub_block=01 with axis=0001 for 1 cycle -> block=1 for 1 cycle, axis_block_info=0001, first_idx=0, event_cnt=1.
REQ-032 THRESH=4: seq_block high 3 cycles, low 1 cycle, then high 4 cycles -> no block for the first run; block rises on the 4th edge of the second run; event_cnt=1.
REQ-033 STICKY=1, THRESH=2: seq_block high 2 cycles then low -> block stays 1 and info stays frozen; clear pulse -> block=0 next cycle and info=0.
REQ-034 NUM_SUB=4: cand[3] and cand[1] rise together -> first_idx=1; info shows pair1 and pair3 only; a sub_block=1 pair with axis=00 contributes 0.
REQ-035 CNT_W=2: 5 block entries -> event_cnt saturates at 3; clear leaves event_cnt at 3; async reset -> 0 with no clock edge.
REQ-036 Reset asserted in SUSPECT at run=THRESH-2 -> no block; after release, block rises only after THRESH new consecutive cycles.

Source files
------------

// File: rtl/aesl_deadlock_param_monitor.sv
// Deadlock monitor: qualifies per-sub-instance block flags with their AXIS stall
// pairs and reports a deadlock after THRESH consecutive blocked cycles.
module aesl_deadlock_param_monitor #(
    parameter int unsigned NUM_SUB = 2,
    parameter int unsigned THRESH  = 1,
    parameter int unsigned STICKY  = 0,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned IDX_W  = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [2*NUM_SUB-1:0]   axis_block_sigs,
    input  logic [NUM_SUB-1:0]     sub_block,
    output logic [2*NUM_SUB-1:0]   axis_block_info,
    output logic                   block,
    output logic [IDX_W-1:0]       first_idx,
    output logic [CNT_W-1:0]       event_cnt
);

    typedef enum logic [1:0] {IDLE, SUSPECT, BLOCKED} state_t;

    localparam logic [15:0] RUN_LAST = 16'(THRESH - 1);

    state_t               state_q, state_d;
    logic [15:0]          run_q, run_d;
    logic [2*NUM_SUB-1:0] info_q, info_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_SUB-1:0]   cand;
    logic                 seq_block;
    logic [2*NUM_SUB-1:0] cap_info;
    logic [IDX_W-1:0]     cap_idx;
    logic                 found;

    always_comb begin
        cand     = '0;
        cap_info = '0;
        cap_idx  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_SUB; i++) begin
            cand[i] = sub_block[i] & (axis_block_sigs[2*i] | axis_block_sigs[2*i+1]);
            cap_info[2*i +: 2] = axis_block_sigs[2*i +: 2] & {2{cand[i]}};
            if (cand[i] && !found) begin
                cap_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
        seq_block = |cand;
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        info_d  = info_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            run_d   = '0;
            info_d  = '0;
            first_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    run_d = '0;
                    if (seq_block) begin
                        if (THRESH == 1) begin
                            state_d = BLOCKED;
                            info_d  = cap_info;
                            first_d = cap_idx;
                            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        end else begin
                            state_d = SUSPECT;
                            run_d   = 16'd1;
                        end
                    end
                end
                SUSPECT: begin
                    if (!seq_block) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d = BLOCKED;
                        run_d   = '0;
                        info_d  = cap_info;
                        first_d = cap_idx;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        run_d = run_q + 16'd1;
                    end
                end
                BLOCKED: begin
                    // Non-sticky mode tracks the live stall pattern; sticky mode freezes the snapshot.
                    if (STICKY == 0) begin
                        if (!seq_block) begin
                            state_d = IDLE;
                        end else begin
                            info_d = cap_info;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            info_q  <= '0;
            first_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            info_q  <= info_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
        end
    end

    assign block           = (state_q == BLOCKED);
    assign axis_block_info = block ? info_q : '0;
    assign first_idx       = first_q;
    assign event_cnt       = cnt_q;

endmodule
